// File: rtl/seq_detect_param_if.sv
// seq_detect_param_if: serial stream, control and match-status signals of the sequence detector
interface seq_detect_param_if #(
  parameter int CNT_W = 8
);
  logic             data_valid;
  logic             data;
  logic             overlap_en;
  logic             clr_cnt;
  logic             flag;
  logic [CNT_W-1:0] match_cnt;
  modport master (output data_valid, data, overlap_en, clr_cnt, input flag, match_cnt);
  modport slave  (input data_valid, data, overlap_en, clr_cnt, output flag, match_cnt);
endinterface

// File: rtl/seq_detect_param.sv
// seq_detect_param: masked sliding-window bit-sequence detector with overlap mode and saturating match counter
module seq_detect_param #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
  parameter logic [SEQ_LEN-1:0] MASK    = 4'b1111,
  parameter int                 CNT_W   = 8
) (
  input logic               clk,
  input logic               rst,
  seq_detect_param_if.slave bus
);
  localparam int FW = $clog2(SEQ_LEN);
  localparam logic [FW-1:0] FULL = FW'(SEQ_LEN - 1);
  // Only the youngest SEQ_LEN-1 bits are kept; the oldest history bit would fall out of every window.
  logic [SEQ_LEN-2:0] hist;
  logic [SEQ_LEN-1:0] window;
  logic [FW-1:0]      fill, fill_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               match;
  always_comb begin
    window   = {hist, bus.data};
    match    = bus.data_valid && fill == FULL && ((window ^ PATTERN) & MASK) == '0;
    fill_nxt = !bus.data_valid ? fill :
               match           ? (bus.overlap_en ? fill : '0) :
               fill == FULL    ? fill : fill + FW'(1);
    cnt_nxt  = bus.clr_cnt                       ? '0 :
               (match && !(&bus.match_cnt))      ? bus.match_cnt + CNT_W'(1) : bus.match_cnt;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hist          <= '0;
      fill          <= '0;
      bus.flag      <= 1'b0;
      bus.match_cnt <= '0;
    end else begin
      if (bus.data_valid) hist <= window[SEQ_LEN-2:0];
      fill          <= fill_nxt;
      bus.flag      <= match;
      bus.match_cnt <= cnt_nxt;
    end
endmodule
